// File: rtl/axis_input_join.sv
// rtl/axis_input_join.sv - joins PIXEL_STREAMS pixel streams and one weights stream into one registered output beat
module axis_input_join #(
    parameter int PIXEL_STREAMS   = 2,
    parameter int UNITS           = 2,
    parameter int WORD_WIDTH      = 8,
    parameter int WEIGHT_WORDS    = 12,
    parameter int TUSER_PIX_WIDTH = 3,
    parameter int TUSER_W_WIDTH   = 8,
    parameter logic [TUSER_PIX_WIDTH+TUSER_W_WIDTH-1:0] VALID_GATE_MASK = '0,
    parameter int COUNT_BITS      = 16
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [PIXEL_STREAMS-1:0]                   s_axis_pixels_tvalid,
    output logic [PIXEL_STREAMS-1:0]                   s_axis_pixels_tready,
    input  logic [PIXEL_STREAMS-1:0]                   s_axis_pixels_tlast,
    input  logic [PIXEL_STREAMS*UNITS*WORD_WIDTH-1:0]  s_axis_pixels_tdata,
    input  logic [TUSER_PIX_WIDTH-1:0]                 s_axis_pixels_tuser,
    input  logic                                       s_axis_weights_tvalid,
    output logic                                       s_axis_weights_tready,
    input  logic                                       s_axis_weights_tlast,
    input  logic [WEIGHT_WORDS*WORD_WIDTH-1:0]         s_axis_weights_tdata,
    input  logic [TUSER_W_WIDTH-1:0]                   s_axis_weights_tuser,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,
    output logic [PIXEL_STREAMS*UNITS*WORD_WIDTH-1:0]  m_axis_pixels_tdata,
    output logic [WEIGHT_WORDS*WORD_WIDTH-1:0]         m_axis_weights_tdata,
    output logic [TUSER_PIX_WIDTH+TUSER_W_WIDTH-1:0]   m_axis_tuser,
    output logic                                       err_last_mismatch,
    output logic [COUNT_BITS-1:0]                      beat_count
);
    localparam int PIX_DW = UNITS * WORD_WIDTH;
    localparam int W_DW   = WEIGHT_WORDS * WORD_WIDTH;
    localparam int UW     = TUSER_PIX_WIDTH + TUSER_W_WIDTH;
    localparam int WE     = W_DW + 1 + TUSER_W_WIDTH;

    // Pixel FIFOs: entry = {tlast, tdata}; stream 0's tuser rides alongside with stream 0's pointers.
    logic [PIX_DW:0]              pix_mem_q [PIXEL_STREAMS][2];
    logic [TUSER_PIX_WIDTH-1:0]   puser_mem_q [2];
    logic [1:0]                   pix_cnt_q [PIXEL_STREAMS];
    logic [1:0]                   pix_cnt_d [PIXEL_STREAMS];
    logic [PIXEL_STREAMS-1:0]     pix_rd_q, pix_rdy_q, pix_push, pix_nonempty, pix_head_last;
    logic [PIXEL_STREAMS*PIX_DW-1:0] pix_head_data;

    logic [WE-1:0]                w_mem_q [2];
    logic [1:0]                   w_cnt_q, w_cnt_d;
    logic                         w_rd_q, w_rdy_q, w_push, w_nonempty;
    logic [WE-1:0]                w_head;

    logic                         fire, mismatch;
    logic                         m_valid_q, m_last_q, err_q;
    logic [PIXEL_STREAMS*PIX_DW-1:0] m_pix_q;
    logic [W_DW-1:0]              m_w_q;
    logic [UW-1:0]                m_user_q;
    logic [COUNT_BITS-1:0]        count_q;

    always_comb begin
        pix_nonempty  = '0;
        pix_head_last = '0;
        pix_head_data = '0;
        for (int k = 0; k < PIXEL_STREAMS; k++) begin
            pix_nonempty[k] = (pix_cnt_q[k] != 2'd0);
            {pix_head_last[k], pix_head_data[k*PIX_DW +: PIX_DW]} = pix_mem_q[k][pix_rd_q[k]];
        end
    end

    assign w_nonempty = (w_cnt_q != 2'd0);
    assign w_head     = w_mem_q[w_rd_q];
    assign fire       = (&pix_nonempty) && w_nonempty && (!m_valid_q || m_axis_tready);
    assign mismatch   = |(pix_head_last ^ {PIXEL_STREAMS{w_head[W_DW]}});

    always_comb begin
        pix_push = s_axis_pixels_tvalid & pix_rdy_q;
        for (int k = 0; k < PIXEL_STREAMS; k++) begin
            pix_cnt_d[k] = pix_cnt_q[k] + {1'b0, pix_push[k]} - {1'b0, fire};
        end
        w_push  = s_axis_weights_tvalid && w_rdy_q;
        w_cnt_d = w_cnt_q + {1'b0, w_push} - {1'b0, fire};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < PIXEL_STREAMS; k++) begin
                pix_cnt_q[k] <= 2'd0;
            end
            pix_rd_q  <= '0;
            pix_rdy_q <= '0;
            w_cnt_q   <= 2'd0;
            w_rd_q    <= 1'b0;
            w_rdy_q   <= 1'b0;
        end else begin
            for (int k = 0; k < PIXEL_STREAMS; k++) begin
                pix_cnt_q[k] <= pix_cnt_d[k];
                pix_rdy_q[k] <= !pix_cnt_d[k][1];
                pix_rd_q[k]  <= pix_rd_q[k] ^ fire;
            end
            w_cnt_q <= w_cnt_d;
            w_rdy_q <= !w_cnt_d[1];
            w_rd_q  <= w_rd_q ^ fire;
        end
    end

    // Storage needs no reset: emptiness is tracked by the counters alone.
    always_ff @(posedge aclk) begin
        for (int k = 0; k < PIXEL_STREAMS; k++) begin
            if (pix_push[k]) begin
                pix_mem_q[k][pix_rd_q[k] ^ pix_cnt_q[k][0]] <=
                    {s_axis_pixels_tlast[k], s_axis_pixels_tdata[k*PIX_DW +: PIX_DW]};
            end
        end
        if (pix_push[0]) begin
            puser_mem_q[pix_rd_q[0] ^ pix_cnt_q[0][0]] <= s_axis_pixels_tuser;
        end
        if (w_push) begin
            w_mem_q[w_rd_q ^ w_cnt_q[0]] <= {s_axis_weights_tuser, s_axis_weights_tlast, s_axis_weights_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_pix_q   <= '0;
            m_w_q     <= '0;
            m_user_q  <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            if (fire) begin
                m_valid_q <= 1'b1;
                m_last_q  <= w_head[W_DW];
                m_pix_q   <= pix_head_data;
                m_w_q     <= w_head[W_DW-1:0];
                m_user_q  <= {w_head[WE-1 -: TUSER_W_WIDTH], puser_mem_q[pix_rd_q[0]]};
                if (mismatch) begin
                    err_q <= 1'b1;
                end
            end else if (m_valid_q && m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
            if (m_valid_q && m_axis_tready) begin
                count_q <= m_last_q ? '0 : count_q + COUNT_BITS'(1);
            end
        end
    end

    assign s_axis_pixels_tready  = pix_rdy_q;
    assign s_axis_weights_tready = w_rdy_q;
    assign m_axis_tvalid         = m_valid_q;
    assign m_axis_tlast          = m_last_q;
    assign m_axis_pixels_tdata   = m_pix_q;
    assign m_axis_weights_tdata  = m_w_q;
    assign m_axis_tuser          = m_user_q & (~VALID_GATE_MASK | {UW{m_valid_q}});
    assign err_last_mismatch     = err_q;
    assign beat_count            = count_q;
endmodule
